// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU datapath types: word, RAM state and arbiter state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arbstate_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port RAM arbiter between icache and dcache, dcache
//            priority, grant held until RAM reports ACCESS.
//            Optional macro ARB_STARVE_GUARD_EN bounds icache starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import cpu_types_pkg::*;

module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    arbstate_t r_state;
    arbstate_t w_next_state;
    logic      w_access;
    logic      w_starved;

    assign w_access = (ramstate == ACCESS);

    if (STARVE_MAX < 1) begin : g_param_check
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve_cnt;

    // Counts dcache completions the waiting icache has had to sit through.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= '0;
        end else if (r_state == IGNT && w_access) begin
            r_starve_cnt <= '0;
        end else if (r_state == DGNT && w_access && iREN && r_starve_cnt != c_CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_starved = iREN && (r_starve_cnt == c_CNT_MAX);
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        iload        = '0;
        dwait        = 1'b1;
        dload        = '0;

        case (r_state)
            IDLE: begin
                if (w_starved) begin
                    w_next_state = IGNT;
                end else if (dREN || dWEN) begin
                    w_next_state = DGNT;
                end else if (iREN) begin
                    w_next_state = IGNT;
                end
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                dload    = ramload;
                dwait    = !w_access;
                // Dropped request aborts; completion always passes through IDLE.
                if (!(dREN || dWEN) || w_access) begin
                    w_next_state = IDLE;
                end
            end

            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = !w_access;
                if (!iREN || w_access) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
